// File: rtl/control_unit.sv
// Single-cycle MIPS-subset control decoder with sticky illegal-instruction flag.
// Optional macro CTRL_REG_OUT_EN registers every decode output (1-cycle latency).
module control_unit (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Cmp_RsRt,
  output logic [1:0] PCSrc,
  output logic       IF_Flush,
  output logic       SignExt,
  output logic       NoDest,
  output logic [2:0] ALUCtrl,
  output logic       ALUSrc,
  output logic       RegDst,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       Branch,
  output logic       Link,
  output logic       MfHi,
  output logic       Illegal,
  output logic       IllegalSeen
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned PC_W  = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_R2    = 6'b011100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [OP_W-1:0] FN_DIV  = 6'b011010;
  localparam logic [OP_W-1:0] FN_MFHI = 6'b010000;
  localparam logic [OP_W-1:0] FN_JR   = 6'b001000;
  localparam logic [OP_W-1:0] FN_MUL  = 6'b000010;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLL = 3'b100;
  localparam logic [ALU_W-1:0] ALU_LUI = 3'b101;
  localparam logic [ALU_W-1:0] ALU_MUL = 3'b110;
  localparam logic [ALU_W-1:0] ALU_DIV = 3'b111;

  localparam logic [PC_W-1:0] PC_SEQ    = 2'b00;
  localparam logic [PC_W-1:0] PC_BRANCH = 2'b01;
  localparam logic [PC_W-1:0] PC_JUMP   = 2'b10;
  localparam logic [PC_W-1:0] PC_REG    = 2'b11;

  typedef struct packed {
    logic [PC_W-1:0]  pcsrc;
    logic             if_flush;
    logic             sign_ext;
    logic             no_dest;
    logic [ALU_W-1:0] alu_ctrl;
    logic             alu_src;
    logic             reg_dst;
    logic             mem_write;
    logic             mem_read;
    logic             reg_write;
    logic             mem_to_reg;
    logic             branch;
    logic             link;
    logic             mfhi;
    logic             illegal;
  } ctrl_t;

  ctrl_t ctrl_d;
  ctrl_t ctrl_out;
  logic  illegal_seen_q;

  // Instruction decode; anything not matched collapses to an illegal NOP.
  always_comb begin
    ctrl_d = '0;
    case (Opcode)
      OP_RTYPE: begin
        case (Funct)
          FN_ADD: begin
            ctrl_d.reg_dst   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_ctrl  = ALU_ADD;
          end
          FN_SUB: begin
            ctrl_d.reg_dst   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_ctrl  = ALU_SUB;
          end
          FN_SLT: begin
            ctrl_d.reg_dst   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_ctrl  = ALU_SLT;
          end
          FN_SLL: begin
            ctrl_d.reg_dst   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_ctrl  = ALU_SLL;
          end
          FN_DIV: ctrl_d.alu_ctrl = ALU_DIV;
          FN_MFHI: begin
            ctrl_d.reg_dst   = 1'b1;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.mfhi      = 1'b1;
          end
          FN_JR:   ctrl_d.pcsrc   = PC_REG;
          default: ctrl_d.illegal = 1'b1;
        endcase
      end
      OP_R2: begin
        if (Funct == FN_MUL) begin
          ctrl_d.reg_dst   = 1'b1;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_ctrl  = ALU_MUL;
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      OP_ADDI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.sign_ext  = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = ALU_ADD;
      end
      OP_ORI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = ALU_OR;
      end
      OP_LUI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = ALU_LUI;
      end
      OP_LW: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.sign_ext   = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.sign_ext  = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_d.branch   = 1'b1;
        ctrl_d.sign_ext = 1'b1;
        ctrl_d.alu_ctrl = ALU_SUB;
        // bne takes the branch on inequality, beq on equality
        if (Cmp_RsRt ^ (Opcode == OP_BNE)) ctrl_d.pcsrc = PC_BRANCH;
      end
      OP_J: ctrl_d.pcsrc = PC_JUMP;
      OP_JAL: begin
        ctrl_d.pcsrc     = PC_JUMP;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.link      = 1'b1;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
    ctrl_d.no_dest  = ~ctrl_d.reg_write;
    ctrl_d.if_flush = (ctrl_d.pcsrc != PC_SEQ);
  end

`ifdef CTRL_REG_OUT_EN
  ctrl_t ctrl_q;

  // Registered outputs; reset parks them at the NOP pattern (only NoDest high).
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ctrl_q <= '{no_dest: 1'b1, default: '0};
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ctrl_out = ctrl_q;
`else
  assign ctrl_out = ctrl_d;
`endif

  // Sticky flag sampled from the visible Illegal output.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      illegal_seen_q <= 1'b0;
    end else if (ctrl_out.illegal) begin
      illegal_seen_q <= 1'b1;
    end
  end

  assign PCSrc       = ctrl_out.pcsrc;
  assign IF_Flush    = ctrl_out.if_flush;
  assign SignExt     = ctrl_out.sign_ext;
  assign NoDest      = ctrl_out.no_dest;
  assign ALUCtrl     = ctrl_out.alu_ctrl;
  assign ALUSrc      = ctrl_out.alu_src;
  assign RegDst      = ctrl_out.reg_dst;
  assign MemWrite    = ctrl_out.mem_write;
  assign MemRead     = ctrl_out.mem_read;
  assign RegWrite    = ctrl_out.reg_write;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign Branch      = ctrl_out.branch;
  assign Link        = ctrl_out.link;
  assign MfHi        = ctrl_out.mfhi;
  assign Illegal     = ctrl_out.illegal;
  assign IllegalSeen = illegal_seen_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random decode
// against an instruction-level reference model.
`timescale 1ns/1ps
module tb_control_unit;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [5:0] Opcode, Funct;
  logic       Cmp_RsRt;
  logic [1:0] PCSrc;
  logic [2:0] ALUCtrl;
  logic IF_Flush, SignExt, NoDest, ALUSrc, RegDst, MemWrite, MemRead;
  logic RegWrite, MemtoReg, Branch, Link, MfHi, Illegal, IllegalSeen;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Cmp_RsRt(Cmp_RsRt),
    .PCSrc(PCSrc), .IF_Flush(IF_Flush), .SignExt(SignExt), .NoDest(NoDest),
    .ALUCtrl(ALUCtrl), .ALUSrc(ALUSrc), .RegDst(RegDst), .MemWrite(MemWrite),
    .MemRead(MemRead), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Branch(Branch),
    .Link(Link), .MfHi(MfHi), .Illegal(Illegal), .IllegalSeen(IllegalSeen)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0] pcsrc;
    logic if_flush, sign_ext, no_dest;
    logic [2:0] alu;
    logic alu_src, reg_dst, mem_write, mem_read, reg_write, mem_to_reg;
    logic branch, link, mfhi, illegal;
  } exp_t;

  typedef enum int {K_ADD, K_SUB, K_SLT, K_SLL, K_DIV, K_MFHI, K_JR, K_MUL, K_ADDI,
                    K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_BAD} kind_t;

  exp_t obs;
  assign obs = {PCSrc, IF_Flush, SignExt, NoDest, ALUCtrl, ALUSrc, RegDst, MemWrite,
                MemRead, RegWrite, MemtoReg, Branch, Link, MfHi, Illegal};

  int   total = 0;
  int   bad   = 0;
  exp_t exp_cur, exp_prev;
  logic seen_exp;

  localparam logic [5:0] LEGAL_OP [17] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
    6'h00, 6'h1c, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
  localparam logic [5:0] LEGAL_FN [17] = '{6'h20, 6'h22, 6'h2a, 6'h00, 6'h1a, 6'h10,
    6'h08, 6'h02, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) begin
      case (fn)
        6'd32: return K_ADD;
        6'd34: return K_SUB;
        6'd42: return K_SLT;
        6'd0:  return K_SLL;
        6'd26: return K_DIV;
        6'd16: return K_MFHI;
        6'd8:  return K_JR;
        default: return K_BAD;
      endcase
    end
    if (op == 6'd28) return (fn == 6'd2) ? K_MUL : K_BAD;
    case (op)
      6'd8:  return K_ADDI;
      6'd13: return K_ORI;
      6'd15: return K_LUI;
      6'd35: return K_LW;
      6'd43: return K_SW;
      6'd4:  return K_BEQ;
      6'd5:  return K_BNE;
      6'd2:  return K_J;
      6'd3:  return K_JAL;
      default: return K_BAD;
    endcase
  endfunction

  // Instruction-level expectation: per-mnemonic control table plus the derived rules.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic cmp);
    exp_t e = '0;
    case (classify(op, fn))
      K_ADD:  begin e.reg_dst = 1; e.reg_write = 1; e.alu = 3'd0; end
      K_SUB:  begin e.reg_dst = 1; e.reg_write = 1; e.alu = 3'd1; end
      K_SLT:  begin e.reg_dst = 1; e.reg_write = 1; e.alu = 3'd3; end
      K_SLL:  begin e.reg_dst = 1; e.reg_write = 1; e.alu = 3'd4; end
      K_MUL:  begin e.reg_dst = 1; e.reg_write = 1; e.alu = 3'd6; end
      K_DIV:  e.alu = 3'd7;
      K_MFHI: begin e.reg_dst = 1; e.reg_write = 1; e.mfhi = 1; end
      K_JR:   e.pcsrc = 2'd3;
      K_ADDI: begin e.alu_src = 1; e.sign_ext = 1; e.reg_write = 1; e.alu = 3'd0; end
      K_ORI:  begin e.alu_src = 1; e.reg_write = 1; e.alu = 3'd2; end
      K_LUI:  begin e.alu_src = 1; e.reg_write = 1; e.alu = 3'd5; end
      K_LW:   begin e.alu_src = 1; e.sign_ext = 1; e.mem_read = 1; e.mem_to_reg = 1;
                    e.reg_write = 1; e.alu = 3'd0; end
      K_SW:   begin e.alu_src = 1; e.sign_ext = 1; e.mem_write = 1; e.alu = 3'd0; end
      K_BEQ:  begin e.branch = 1; e.sign_ext = 1; e.alu = 3'd1; e.pcsrc = cmp ? 2'd1 : 2'd0; end
      K_BNE:  begin e.branch = 1; e.sign_ext = 1; e.alu = 3'd1; e.pcsrc = cmp ? 2'd0 : 2'd1; end
      K_J:    e.pcsrc = 2'd2;
      K_JAL:  begin e.pcsrc = 2'd2; e.reg_write = 1; e.link = 1; end
      default: e.illegal = 1;
    endcase
    e.no_dest  = !e.reg_write;
    e.if_flush = (e.pcsrc != 2'd0);
    return e;
  endfunction

  function automatic exp_t reset_outputs();
    exp_t e = '0;
    e.no_dest = 1'b1;
    return e;
  endfunction

  // Drive one instruction through a clock edge and advance the reference state.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic cmp);
    logic pre_ill;
    Opcode = op; Funct = fn; Cmp_RsRt = cmp;
    exp_cur = model(op, fn, cmp);
`ifdef CTRL_REG_OUT_EN
    pre_ill = exp_prev.illegal;
`else
    pre_ill = exp_cur.illegal;
`endif
    @(posedge Clock);
    if (Reset && pre_ill) seen_exp = 1'b1;
    #1;
    exp_prev = exp_cur;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Opcode = 6'h00; Funct = 6'h20; Cmp_RsRt = 1'b0;
    seen_exp = 1'b0;
    #2;
    total++;
    if (IllegalSeen !== 1'b0) begin
      $display("FAIL reset_seen: got %b want 0", IllegalSeen); bad++;
    end
`ifdef CTRL_REG_OUT_EN
    exp_cur = reset_outputs();
`else
    exp_cur = model(Opcode, Funct, Cmp_RsRt);
`endif
    total++;
    if (obs !== exp_cur) begin
      $display("FAIL reset_outputs: got %h want %h", obs, exp_cur); bad++;
    end
    @(negedge Clock);
    Reset = 1'b1;
`ifdef CTRL_REG_OUT_EN
    exp_prev = reset_outputs();
`else
    exp_prev = exp_cur;
`endif
  endtask

  task automatic test_rtype();
`ifndef CTRL_REG_OUT_EN
    Opcode = 6'h00; Funct = 6'h22; Cmp_RsRt = 1'b1;
    #1;
    total++;
    if (obs !== model(6'h00, 6'h22, 1'b1)) begin
      $display("FAIL zero_latency_sub: got %h want %h", obs, model(6'h00, 6'h22, 1'b1)); bad++;
    end
`endif
    for (int i = 0; i < 8; i++) begin
      step(LEGAL_OP[i], LEGAL_FN[i], 1'b0);
      total++;
      if (obs !== exp_cur) begin
        $display("FAIL rtype[%0d]: got %h want %h", i, obs, exp_cur); bad++;
      end
    end
    step(6'h00, 6'h20, 1'b0);
    total++;
    if (!(RegDst === 1 && RegWrite === 1 && ALUCtrl === 3'b000 && PCSrc === 2'b00 && NoDest === 0)) begin
      $display("FAIL add_fields: got rd=%b rw=%b alu=%b pc=%b nd=%b want 1 1 000 00 0",
               RegDst, RegWrite, ALUCtrl, PCSrc, NoDest); bad++;
    end
  endtask

  task automatic test_mem_imm();
    for (int i = 8; i < 13; i++) begin
      step(LEGAL_OP[i], 6'($urandom), 1'($urandom));
      total++;
      if (obs !== exp_cur) begin
        $display("FAIL mem_imm[%0d]: got %h want %h", i, obs, exp_cur); bad++;
      end
    end
  endtask

  task automatic test_branch();
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 2; c++) begin
        step(b == 0 ? 6'h04 : 6'h05, 6'($urandom), 1'(c));
        total++;
        if (obs !== exp_cur) begin
          $display("FAIL branch b%0d c%0d: got %h want %h", b, c, obs, exp_cur); bad++;
        end
      end
    end
  endtask

  task automatic test_jump();
    step(6'h02, 6'h15, 1'b1);
    total++;
    if (obs !== exp_cur) begin $display("FAIL j: got %h want %h", obs, exp_cur); bad++; end
    step(6'h03, 6'h00, 1'b0);
    total++;
    if (obs !== exp_cur) begin $display("FAIL jal: got %h want %h", obs, exp_cur); bad++; end
    step(6'h00, 6'h08, 1'b1);
    total++;
    if (obs !== exp_cur) begin $display("FAIL jr: got %h want %h", obs, exp_cur); bad++; end
    total++;
    if (IllegalSeen !== seen_exp) begin
      $display("FAIL seen_after_legal: got %b want %b", IllegalSeen, seen_exp); bad++;
    end
  endtask

  task automatic test_illegal();
    step(6'h3f, 6'h00, 1'b0);
    total++;
    if (obs !== exp_cur) begin $display("FAIL bad_opcode: got %h want %h", obs, exp_cur); bad++; end
    step(6'h00, 6'h3f, 1'b1);
    total++;
    if (obs !== exp_cur) begin $display("FAIL bad_funct: got %h want %h", obs, exp_cur); bad++; end
    step(6'h1c, 6'h20, 1'b0);
    total++;
    if (obs !== exp_cur) begin $display("FAIL bad_r2_funct: got %h want %h", obs, exp_cur); bad++; end
    total++;
    if (IllegalSeen !== seen_exp) begin
      $display("FAIL seen_set: got %b want %b", IllegalSeen, seen_exp); bad++;
    end
    #2 Reset = 1'b0;
    #1;
    seen_exp = 1'b0;
    total++;
    if (IllegalSeen !== 1'b0) begin
      $display("FAIL seen_async_clear: got %b want 0", IllegalSeen); bad++;
    end
    @(negedge Clock);
    Reset = 1'b1;
`ifdef CTRL_REG_OUT_EN
    exp_prev = reset_outputs();
`endif
  endtask

  task automatic test_random();
    int idx;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) != 0) begin
        idx = $urandom_range(16);
        step(LEGAL_OP[idx], (idx < 8) ? LEGAL_FN[idx] : 6'($urandom), 1'($urandom));
      end else begin
        step(6'($urandom), 6'($urandom), 1'($urandom));
      end
      total++;
      if (obs !== exp_cur) begin
        $display("FAIL random[%0d] op=%h fn=%h: got %h want %h", n, Opcode, Funct, obs, exp_cur); bad++;
      end
      total++;
      if (IllegalSeen !== seen_exp) begin
        $display("FAIL random_seen[%0d]: got %b want %b", n, IllegalSeen, seen_exp); bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem_imm();
    test_branch();
    test_jump();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
